tdm_demux_4ch: RTL and testbench
================================

TDM_DEMUX_4CH -- requirements
Module: tdm_demux_4ch

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of each sample and of each channel output.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: din  input  WIDTH  serial time-multiplexed sample stream.
REQ-005 Port: din_valid  input  1  din carries a sample this cycle.
REQ-006 Port: sync  input  1  qualified by din_valid; marks the current sample as channel 0.
REQ-007 Port: i0, i1, i2, i3  output  WIDTH each  demultiplexed channel samples of the last complete frame.
REQ-008 Port: frame_valid  output  1  one-cycle pulse; i0..i3 were just updated with a complete frame.
REQ-009 Port: frame_err  output  1  one-cycle pulse; a partial frame was discarded on early sync.
REQ-010 Port: sel  output  2  channel index the next accepted sample is written to.

Function
REQ-011 The block SHALL implement a two-state FSM: HUNT (no frame alignment) and RUN (aligned).
REQ-012 An accepted sample SHALL be a rising edge with din_valid=1; with din_valid=0 all state, sel and shadow registers SHALL hold.
REQ-013 sync with din_valid=0 SHALL be ignored.
REQ-014 In HUNT, accepted samples without sync SHALL be discarded, and sel SHALL stay 0.
REQ-015 In HUNT, an accepted sample with sync=1 SHALL be stored as channel 0, set sel=1 and move the FSM to RUN.
REQ-016 In RUN, each accepted sample SHALL be stored in shadow[sel], and sel SHALL increment modulo 4 (3 wraps to 0).
REQ-017 On the edge accepting the sel=3 sample, i0..i2 SHALL load from shadow[0..2] and i3 SHALL load from din, so all four update on the same edge.
REQ-018 frame_valid SHALL be high for exactly the cycle following the edge that accepts the sel=3 sample; back-to-back frames SHALL give pulses every 4 accepted samples.
REQ-019 i0..i3 SHALL hold their values between frame updates and SHALL never show a partial frame.
REQ-020 In RUN, sync with sel=0 SHALL be normal alignment, with no error.
REQ-021 In RUN, sync with sel=1..3 SHALL pulse frame_err for one cycle, discard the partial frame (i0..i3 unchanged), store the sample as channel 0, set sel=1 and stay in RUN.
REQ-022 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-023 The FSM SHALL never return from RUN to HUNT except by reset.
REQ-024 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-025 While rst=1 (asynchronously), the FSM SHALL be HUNT, sel=0, shadow registers 0, i0..i3=0, frame_valid=0 and frame_err=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid or frame_err pulse.
REQ-027 After rst deasserts, the block SHALL require a sync to leave HUNT.

Structure
REQ-028 Shared package tdm_pkg SHALL hold NUM_CH=4, CH_W=2 and the FSM state encoding (HUNT=0, RUN=1).
REQ-029 The modulo-4 channel counter with load-to-1 and clear SHALL be a sub-module named tdm_ch_counter; the remaining logic stays in tdm_demux_4ch.

Verification (WIDTH=4)
REQ-030 Stimulus: after reset, send valid samples 5,6 without sync, then sync+A,B,C,D. Response: no pulses during 5,6; frame_valid once; i0..i3=A,B,C,D.
REQ-031 Stimulus: two back-to-back frames 1,2,3,4 then 9,8,7,6 with sync on the first of each. Response: frame_valid pulses exactly 4 accepted samples apart; final i0..i3=9,8,7,6; frame_err never set.
REQ-032 Stimulus: frame 1,2 then sync+F,E,D,C. Response: frame_err one pulse at F; i0..i3 keep the previous frame until the pulse after C; then i0..i3=F,E,D,C.
REQ-033 Stimulus: frame 3,4,5,6 with din_valid=0 gaps of 1-3 cycles between samples and sync toggled during the gaps. Response: identical result to the gapless case; sel holds during gaps.
REQ-034 Stimulus: assert rst after 2 samples of a frame, then release. Response: all outputs 0 immediately (asynchronously); no pulses; FSM in HUNT until the next sync.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and FSM state encoding for the 4-channel TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_ch_counter.sv
// Modulo-4 channel index counter: clear, load-to-1 (frame start) and increment.
module tdm_ch_counter
  import tdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load1,
  input  logic            inc,
  output logic [CH_W-1:0] cnt
);

  logic [CH_W-1:0] cnt_q;

  // Clear wins over load, load wins over increment; increment wraps 3 -> 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load1) begin
      cnt_q <= CH_W'(1);
    end else if (inc) begin
      cnt_q <= cnt_q + CH_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule : tdm_ch_counter

// File: rtl/tdm_demux_4ch.sv
// 4-channel TDM demultiplexer: aligns on sync, collects samples into shadow
// registers and publishes a whole frame to i0..i3 at once.
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] i0,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] i3,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       sel
);

  state_e           state_q;
  logic [WIDTH-1:0] shadow_q [NUM_CH];
  logic [WIDTH-1:0] out_q    [NUM_CH];
  logic             frame_valid_q;
  logic             frame_err_q;

  logic [CH_W-1:0]  sel_w;
  logic             cnt_clr;
  logic             cnt_load1;
  logic             cnt_inc;

  // Any accepted sync restarts the frame at channel 0 (next index 1); plain
  // samples advance only once aligned, and are discarded while hunting.
  assign cnt_load1 = din_valid & sync;
  assign cnt_inc   = din_valid & ~sync & (state_q == RUN);
  assign cnt_clr   = din_valid & ~sync & (state_q == HUNT);

  tdm_ch_counter u_ch_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (sel_w)
  );

  // FSM with shadow capture, frame publication and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= '0;
        out_q[k]    <= '0;
      end
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            if (sync) begin
              shadow_q[0] <= din;
              state_q     <= RUN;
            end
          end
          RUN: begin
            if (sync) begin
              // Early sync drops the partial frame; outputs stay untouched.
              shadow_q[0] <= din;
              if (sel_w != '0) begin
                frame_err_q <= 1'b1;
              end
            end else begin
              shadow_q[sel_w] <= din;
              if (sel_w == CH_W'(NUM_CH - 1)) begin
                // Last channel comes straight from din so all four update together.
                for (int k = 0; k < NUM_CH - 1; k++) begin
                  out_q[k] <= shadow_q[k];
                end
                out_q[NUM_CH-1] <= din;
                frame_valid_q   <= 1'b1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign i0          = out_q[0];
  assign i1          = out_q[1];
  assign i2          = out_q[2];
  assign i3          = out_q[3];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign sel         = sel_w;

endmodule : tdm_demux_4ch

// File: tb/tb_tdm_demux_4ch.sv
// Directed self-checking bench for tdm_demux_4ch at WIDTH=4.
module tb_tdm_demux_4ch;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] i0, i1, i2, i3;
  logic         frame_valid;
  logic         frame_err;
  logic [1:0]   sel;

  int pass_cnt;
  int total_cnt;

  tdm_demux_4ch #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .i0          (i0),
    .i1          (i1),
    .i2          (i2),
    .i3          (i3),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .sel         (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One accepted sample; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic [W-1:0] d, input logic s);
    din       = d;
    din_valid = 1'b1;
    sync      = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
    $display("sample din=%0h sync=%0b -> sel=%0d fv=%0b fe=%0b i=%0h,%0h,%0h,%0h",
             d, s, sel, frame_valid, frame_err, i0, i1, i2, i3);
  endtask

  // Idle cycles with din_valid=0, sync toggled and junk data: nothing may move.
  task automatic gap(input int n, input logic [1:0] exp_sel);
    for (int g = 0; g < n; g++) begin
      din       = W'($urandom);
      din_valid = 1'b0;
      sync      = g[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      check("gap_sel", 8'(sel), 8'(exp_sel));
      check("gap_fv", 8'(frame_valid), 8'h0);
    end
    sync = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3);
    check({tag, "_i0"}, 8'(i0), 8'(e0));
    check({tag, "_i1"}, 8'(i1), 8'(e1));
    check({tag, "_i2"}, 8'(i2), 8'(e2));
    check({tag, "_i3"}, 8'(i3), 8'(e3));
  endtask

  task automatic check_flags(input string tag, input logic [1:0] e_sel, input logic e_fv, input logic e_fe);
    check({tag, "_sel"}, 8'(sel), 8'(e_sel));
    check({tag, "_fv"}, 8'(frame_valid), 8'(e_fv));
    check({tag, "_fe"}, 8'(frame_err), 8'(e_fe));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    sync      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    check_flags("rst", 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Hunt discards unsynced samples, then sync+A,B,C,D
    send(4'h5, 1'b0); check_flags("hunt5", 2'd0, 1'b0, 1'b0);
    send(4'h6, 1'b0); check_flags("hunt6", 2'd0, 1'b0, 1'b0);
    send(4'hA, 1'b1); check_flags("a", 2'd1, 1'b0, 1'b0);
    send(4'hB, 1'b0); check_flags("b", 2'd2, 1'b0, 1'b0);
    send(4'hC, 1'b0); check_flags("c", 2'd3, 1'b0, 1'b0);
    check_outs("partial", 4'h0, 4'h0, 4'h0, 4'h0);
    send(4'hD, 1'b0); check_flags("d", 2'd0, 1'b1, 1'b0);
    check_outs("abcd", 4'hA, 4'hB, 4'hC, 4'hD);
    @(posedge clk);
    #1;
    check("fv_one_cycle", 8'(frame_valid), 8'h0);
    check_outs("abcd_hold", 4'hA, 4'hB, 4'hC, 4'hD);

    // Back-to-back frames
    send(4'h1, 1'b1); check_flags("f1_1", 2'd1, 1'b0, 1'b0);
    send(4'h2, 1'b0); check_flags("f1_2", 2'd2, 1'b0, 1'b0);
    send(4'h3, 1'b0); check_flags("f1_3", 2'd3, 1'b0, 1'b0);
    send(4'h4, 1'b0); check_flags("f1_4", 2'd0, 1'b1, 1'b0);
    check_outs("f1", 4'h1, 4'h2, 4'h3, 4'h4);
    send(4'h9, 1'b1); check_flags("f2_9", 2'd1, 1'b0, 1'b0);
    check_outs("f2_hold", 4'h1, 4'h2, 4'h3, 4'h4);
    send(4'h8, 1'b0); check_flags("f2_8", 2'd2, 1'b0, 1'b0);
    send(4'h7, 1'b0); check_flags("f2_7", 2'd3, 1'b0, 1'b0);
    send(4'h6, 1'b0); check_flags("f2_6", 2'd0, 1'b1, 1'b0);
    check_outs("f2", 4'h9, 4'h8, 4'h7, 4'h6);

    // Early sync: partial 1,2 discarded, error pulse on F
    send(4'h1, 1'b1); check_flags("p_1", 2'd1, 1'b0, 1'b0);
    send(4'h2, 1'b0); check_flags("p_2", 2'd2, 1'b0, 1'b0);
    send(4'hF, 1'b1); check_flags("p_f", 2'd1, 1'b0, 1'b1);
    check_outs("p_f_hold", 4'h9, 4'h8, 4'h7, 4'h6);
    send(4'hE, 1'b0); check_flags("p_e", 2'd2, 1'b0, 1'b0);
    send(4'hD, 1'b0); check_flags("p_d", 2'd3, 1'b0, 1'b0);
    check_outs("p_d_hold", 4'h9, 4'h8, 4'h7, 4'h6);
    send(4'hC, 1'b0); check_flags("p_c", 2'd0, 1'b1, 1'b0);
    check_outs("fedc", 4'hF, 4'hE, 4'hD, 4'hC);

    // Gapped frame with sync toggling while din_valid=0
    send(4'h3, 1'b1); check_flags("g_3", 2'd1, 1'b0, 1'b0);
    gap(1, 2'd1);
    send(4'h4, 1'b0); check_flags("g_4", 2'd2, 1'b0, 1'b0);
    gap(3, 2'd2);
    send(4'h5, 1'b0); check_flags("g_5", 2'd3, 1'b0, 1'b0);
    gap(2, 2'd3);
    check_outs("g_hold", 4'hF, 4'hE, 4'hD, 4'hC);
    send(4'h6, 1'b0); check_flags("g_6", 2'd0, 1'b1, 1'b0);
    check_outs("gapped", 4'h3, 4'h4, 4'h5, 4'h6);

    // Asynchronous reset in the middle of a frame
    send(4'h1, 1'b1);
    send(4'h2, 1'b0); check_flags("r_pre", 2'd2, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    check_flags("async_rst", 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_flags("post_rst", 2'd0, 1'b0, 1'b0);
    send(4'h7, 1'b0); check_flags("hunt_after_rst_7", 2'd0, 1'b0, 1'b0);
    send(4'h8, 1'b0); check_flags("hunt_after_rst_8", 2'd0, 1'b0, 1'b0);
    check_outs("hunt_after_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    send(4'h1, 1'b1); check_flags("rs_1", 2'd1, 1'b0, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0); check_flags("rs_4", 2'd0, 1'b1, 1'b0);
    check_outs("rs", 4'h1, 4'h2, 4'h3, 4'h4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_tdm_demux_4ch
